score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 31 +++
 rtl/score_display.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: state encoding,
// digit geometry and the active-low seven-segment patterns {g,f,e,d,c,b,a}.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 6;
  localparam int SHIFT_BITS = 20;
  localparam int CNT_W      = 5;
  localparam logic [23:0] MAX_DISPLAY = 24'd999999;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: a BCD digit of 5 or more gets +3 before the
  // shift so that it carries correctly into the next decade.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Maps one BCD digit (plus a blank request) to an active-low segment pattern.
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup; blank and non-decimal codes both dark.
  always_comb begin
    // NOTE: default first so every path assigns seg and no latch is inferred.
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Six-digit score display: captures a changed binary score, converts it to
// BCD with a 20-step double-dabble, saturates at 999999, and updates all
// segment outputs together at the end so no partial value is ever shown.
module score_display
  import score_display_pkg::*;
#(
  parameter int LEADING_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] score,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        overflow
);

  localparam int HEX_W = 7 * NUM_DIGITS;

  // Display shown out of reset: a single "0", or six zeros without blanking.
  localparam logic [HEX_W-1:0] RESET_HEX = (LEADING_BLANK != 0)
    ? {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0}
    : {SEG_0, SEG_0, SEG_0, SEG_0, SEG_0, SEG_0};

  state_e           state_q, state_d;
  logic [23:0]      last_score_q, last_score_d;
  logic [19:0]      operand_q, operand_d;
  logic [23:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_ovf_q, pending_ovf_d;
  logic             ovf_q, ovf_d;
  logic [23:0]      digit_q, digit_d;
  logic [HEX_W-1:0] hex_q, hex_d;

  logic [23:0]           bcd_adj;
  logic [NUM_DIGITS-1:0] blank;
  logic [6:0]            seg_w [NUM_DIGITS];
  logic [HEX_W-1:0]      seg_packed;

  // Per-digit +3 correction applied ahead of each shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = dabble_adjust(bcd_q[4*i +: 4]);
    end
  end

  // Leading-zero blanking: a digit is dark if it and every higher digit are 0;
  // hex0 is never blanked so zero still reads "0".
  always_comb begin
    logic seen_nonzero;
    blank        = '0;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nonzero = seen_nonzero | (bcd_q[4*i +: 4] != 4'd0);
      blank[i]     = (LEADING_BLANK != 0) && !seen_nonzero;
    end
  end

  // Decode the finished accumulator; only sampled into hex_q on the DONE edge.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (bcd_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_w[g])
    );
    assign seg_packed[7*g +: 7] = seg_w[g];
  end

  // Next-state and datapath: capture in IDLE, shift in SHIFT, publish in DONE.
  always_comb begin
    state_d       = state_q;
    last_score_d  = last_score_q;
    operand_d     = operand_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    pending_ovf_d = pending_ovf_q;
    ovf_d         = ovf_q;
    digit_d       = digit_q;
    hex_d         = hex_q;
    case (state_q)
      IDLE: begin
        if (score != last_score_q) begin
          last_score_d = score;
          if (score > MAX_DISPLAY) begin
            operand_d     = MAX_DISPLAY[19:0];
            pending_ovf_d = 1'b1;
          end else begin
            operand_d     = score[19:0];
            pending_ovf_d = 1'b0;
          end
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d     = {bcd_adj[22:0], operand_q[19]};
        operand_d = {operand_q[18:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SHIFT_BITS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        digit_d = bcd_q;
        ovf_d   = pending_ovf_q;
        hex_d   = seg_packed;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset that abandons any conversion.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here is a plain flop (no memory array), so all of
    // them can and do take the reset value.
    if (rst) begin
      state_q       <= IDLE;
      last_score_q  <= '0;
      operand_q     <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      pending_ovf_q <= 1'b0;
      ovf_q         <= 1'b0;
      digit_q       <= '0;
      hex_q         <= RESET_HEX;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q       <= state_d;
      last_score_q  <= last_score_d;
      operand_q     <= operand_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      pending_ovf_q <= pending_ovf_d;
      ovf_q         <= ovf_d;
      digit_q       <= digit_d;
      hex_q         <= hex_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign hex0     = hex_q[6:0];
  assign hex1     = hex_q[13:7];
  assign hex2     = hex_q[20:14];
  assign hex3     = hex_q[27:21];
  assign hex4     = hex_q[34:28];
  assign hex5     = hex_q[41:35];

endmodule
